// File: rtl/ps2_kbd_tx_if.sv
// Host-side write/status bundle for the PS/2 device transmitter.
// The master drives bytes and inhibit; the slave (transmitter) reports buffer and line status.
`timescale 1ns/1ps
interface ps2_kbd_tx_if;
  logic       wr_stb;
  logic [7:0] wr_data;
  logic       inhibit;
  logic       full;
  logic       busy;
  logic       overflow;

  modport master (
    output wr_stb, wr_data, inhibit,
    input  full, busy, overflow
  );

  modport slave (
    input  wr_stb, wr_data, inhibit,
    output full, busy, overflow
  );
endinterface

// File: rtl/ps2_kbd_tx.sv
// PS/2 device-side transmitter: buffers scancode bytes and sends 11-bit odd-parity frames.
// Build option PS2_KBD_TX_FIFO_EN selects a 16-entry FIFO instead of a single holding register.
`timescale 1ns/1ps
module ps2_kbd_tx #(
  parameter int CLK_DIV = 443,
  parameter int GAP_CYC = 886
) (
  input  logic           clk,
  input  logic           reset,
  ps2_kbd_tx_if.slave    bus,
  output logic           ps2_clk,
  output logic           ps2_data
);

  localparam logic [11:0] DIV_LAST = 12'(CLK_DIV - 1);
  localparam logic [11:0] GAP_LAST = (GAP_CYC > 0) ? 12'(GAP_CYC - 1) : 12'd0;
  localparam logic [3:0]  LAST_BIT = 4'd10;

  typedef enum logic [1:0] {
    S_IDLE,
    S_HIGH,
    S_LOW,
    S_GAP
  } state_t;

  state_t      state_q;
  logic [11:0] cnt_q;
  logic [3:0]  bit_q;
  logic [10:0] shift_q;
  logic        ps2_clk_q;
  logic        ps2_data_q;
  logic        busy_q;

  logic        full_q;
  logic        ovf_q;
  logic        wr_acc;
  logic        buf_empty;
  logic [7:0]  buf_head;
  logic        pop;

  assign wr_acc = bus.wr_stb & ~full_q;
  assign pop    = (state_q == S_IDLE) & ~buf_empty & ~bus.inhibit;

  // A write presented while full is lost even if a pop frees a slot that same cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ovf_q <= 1'b0;
    end else if (bus.wr_stb && full_q) begin
      ovf_q <= 1'b1;
    end
  end

`ifdef PS2_KBD_TX_FIFO_EN
  logic [7:0] mem [16];
  logic [3:0] wr_ptr_q, wr_ptr_d;
  logic [3:0] rd_ptr_q, rd_ptr_d;
  logic [4:0] count_q, count_d;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (wr_acc) wr_ptr_d = wr_ptr_q + 4'd1;
    if (pop)    rd_ptr_d = rd_ptr_q + 4'd1;
    case ({wr_acc, pop})
      2'b10:   count_d = count_q + 5'd1;
      2'b01:   count_d = count_q - 5'd1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (wr_acc) mem[wr_ptr_q] <= bus.wr_data;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      full_q   <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      full_q   <= (count_d == 5'd16);
    end
  end

  assign buf_empty = (count_q == 5'd0);
  assign buf_head  = mem[rd_ptr_q];
`else
  logic [7:0] hold_q, hold_d;
  logic       vld_q, vld_d;

  always_comb begin
    hold_d = hold_q;
    vld_d  = vld_q;
    if (pop) vld_d = 1'b0;
    if (wr_acc) begin
      hold_d = bus.wr_data;
      vld_d  = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hold_q <= '0;
      vld_q  <= 1'b0;
      full_q <= 1'b0;
    end else begin
      hold_q <= hold_d;
      vld_q  <= vld_d;
      full_q <= vld_d;
    end
  end

  assign buf_empty = ~vld_q;
  assign buf_head  = hold_q;
`endif

  // Data only ever changes on entry to HIGH, so it is stable across every falling ps2_clk.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      bit_q      <= '0;
      shift_q    <= '1;
      ps2_clk_q  <= 1'b1;
      ps2_data_q <= 1'b1;
      busy_q     <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (pop) begin
            shift_q    <= {1'b1, ~^buf_head, buf_head, 1'b0};
            ps2_data_q <= 1'b0;
            cnt_q      <= '0;
            bit_q      <= '0;
            busy_q     <= 1'b1;
            state_q    <= S_HIGH;
          end
        end
        S_HIGH: begin
          if (cnt_q == DIV_LAST) begin
            cnt_q     <= '0;
            ps2_clk_q <= 1'b0;
            state_q   <= S_LOW;
          end else begin
            cnt_q <= cnt_q + 12'd1;
          end
        end
        S_LOW: begin
          if (cnt_q == DIV_LAST) begin
            cnt_q     <= '0;
            ps2_clk_q <= 1'b1;
            if (bit_q != LAST_BIT) begin
              bit_q      <= bit_q + 4'd1;
              shift_q    <= {1'b1, shift_q[10:1]};
              ps2_data_q <= shift_q[1];
              state_q    <= S_HIGH;
            end else begin
              ps2_data_q <= 1'b1;
              if (GAP_CYC == 0) begin
                busy_q  <= 1'b0;
                state_q <= S_IDLE;
              end else begin
                state_q <= S_GAP;
              end
            end
          end else begin
            cnt_q <= cnt_q + 12'd1;
          end
        end
        S_GAP: begin
          if (cnt_q == GAP_LAST) begin
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            state_q <= S_IDLE;
          end else begin
            cnt_q <= cnt_q + 12'd1;
          end
        end
        default: begin
          state_q    <= S_IDLE;
          ps2_clk_q  <= 1'b1;
          ps2_data_q <= 1'b1;
          busy_q     <= 1'b0;
        end
      endcase
    end
  end

  assign ps2_clk      = ps2_clk_q;
  assign ps2_data     = ps2_data_q;
  assign bus.full     = full_q;
  assign bus.busy     = busy_q;
  assign bus.overflow = ovf_q;

endmodule

// File: tb/tb_ps2_kbd_tx.sv
// Self-checking bench for ps2_kbd_tx: a behavioural PS/2 receiver decodes the lines and
// compares each frame against the queue of bytes the bench expects to be accepted.
`timescale 1ns/1ps
module tb_ps2_kbd_tx;

  localparam int CLK_DIV = 4;
  localparam int GAP_CYC = 8;

  logic clk;
  logic reset;
  logic ps2_clk;
  logic ps2_data;

  ps2_kbd_tx_if bus ();

  ps2_kbd_tx #(
    .CLK_DIV (CLK_DIV),
    .GAP_CYC (GAP_CYC)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .bus      (bus),
    .ps2_clk  (ps2_clk),
    .ps2_data (ps2_data)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Frame a byte the way the protocol defines it: start 0, LSB-first data, odd parity, stop 1.
  function automatic logic [10:0] frame_of(input logic [7:0] b);
    logic par;
    par = ($countones(b) % 2 == 0);
    return {1'b1, par, b, 1'b0};
  endfunction

  logic [7:0]  exp_q[$];
  logic [10:0] cur_bits   = '0;
  logic [10:0] frame_bits = '0;
  int          nb         = 0;
  int          falls      = 0;
  int          frames_rx  = 0;

  always @(negedge ps2_clk or posedge reset) begin
    if (reset) begin
      nb = 0;
    end else begin
      falls++;
      cur_bits[nb] = ps2_data;
      nb++;
      if (nb == 11) begin
        nb = 0;
        frame_bits = cur_bits;
        frames_rx++;
        chk("rx_start", 32'(cur_bits[0]), 0);
        chk("rx_stop", 32'(cur_bits[10]), 1);
        chk("rx_parity", 32'($countones(cur_bits[9:1]) % 2), 1);
        if (exp_q.size() == 0) chk("rx_unexpected_frame", 32'(cur_bits[8:1]), 32'hFFFF);
        else                   chk("rx_byte", 32'(cur_bits[8:1]), 32'(exp_q.pop_front()));
      end
    end
  end

  task automatic wr(input logic [7:0] b);
    @(negedge clk);
    bus.wr_stb  = 1'b1;
    bus.wr_data = b;
    @(negedge clk);
    bus.wr_stb  = 1'b0;
  endtask

  task automatic wait_not_full();
    int n = 0;
    while (bus.full && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (n >= 300) chk("wait_not_full_timeout", 32'(n), 0);
  endtask

  task automatic wait_frames(input int target);
    int n = 0;
    while (frames_rx < target && n < 2000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 2000) chk("wait_frames_timeout", 32'(frames_rx), 32'(target));
  endtask

  task automatic wait_falls(input int target);
    int n = 0;
    while (falls < target && n < 2000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 2000) chk("wait_falls_timeout", 32'(falls), 32'(target));
  endtask

  task automatic drain(input string tag);
    int n = 0;
    while ((exp_q.size() != 0 || bus.busy) && n < 5000) begin
      @(negedge clk);
      n++;
    end
    chk(tag, 32'(exp_q.size()), 0);
  endtask

  // Idle-line cycles between the stop bit's rising clock and the next start bit.
  task automatic measure_gap(output int n);
    int w = 0;
    while (!ps2_clk && w < 100) begin
      @(negedge clk);
      w++;
    end
    n = 0;
    while (ps2_data && ps2_clk && n < 100) begin
      @(negedge clk);
      n++;
    end
  endtask

  initial begin
    #800000;
    $display("FAIL watchdog got=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int base_f;
    int base_r;
    int n;
    int quiet;
    logic [7:0] order [256];
    logic [7:0] b;

    reset       = 1'b1;
    bus.wr_stb  = 1'b0;
    bus.wr_data = '0;
    bus.inhibit = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_ps2_clk", 32'(ps2_clk), 1);
    chk("rst_ps2_data", 32'(ps2_data), 1);
    chk("rst_busy", 32'(bus.busy), 0);
    chk("rst_full", 32'(bus.full), 0);
    chk("rst_overflow", 32'(bus.overflow), 0);
    reset = 1'b0;
    repeat (2) @(negedge clk);

    // Single byte: latency, frame content, falling-edge count, busy length.
    base_f = falls;
    @(negedge clk);
    bus.wr_stb  = 1'b1;
    bus.wr_data = 8'h1C;
    exp_q.push_back(8'h1C);
    @(negedge clk);
    bus.wr_stb = 1'b0;
    chk("lat_n1_data_high", 32'(ps2_data), 1);
    chk("lat_n1_full", 32'(bus.full), 1);
    @(negedge clk);
    chk("lat_n2_start_bit", 32'(ps2_data), 0);
    chk("lat_n2_busy", 32'(bus.busy), 1);
    n = 0;
    while (bus.busy && n < 300) begin
      n++;
      @(negedge clk);
    end
    chk("busy_cycles", 32'(n), 32'(22 * CLK_DIV + GAP_CYC));
    chk("fall_count", 32'(falls - base_f), 11);
    chk("frame_1c", 32'(frame_bits), 32'h438);
    chk("idle_clk", 32'(ps2_clk), 1);
    chk("idle_data", 32'(ps2_data), 1);

    // Three back-to-back bytes: parity, order, inter-frame idle spacing.
    base_r = frames_rx;
    wr(8'hF0); exp_q.push_back(8'hF0);
    wait_not_full();
    wr(8'h00); exp_q.push_back(8'h00);
    wait_frames(base_r + 1);
    chk("parity_f0", 32'(frame_bits[9]), 1);
    measure_gap(n);
    chk("gap_1", 32'(n), 32'(GAP_CYC + 1));
    wait_not_full();
    wr(8'hFF); exp_q.push_back(8'hFF);
    wait_frames(base_r + 2);
    chk("parity_00", 32'(frame_bits[9]), 1);
    measure_gap(n);
    chk("gap_2", 32'(n), 32'(GAP_CYC + 1));
    wait_frames(base_r + 3);
    chk("parity_ff", 32'(frame_bits[9]), 1);
    drain("drain_b2b");

    // Overflow: write while full is dropped and sets the sticky flag.
`ifdef PS2_KBD_TX_FIFO_EN
    bus.inhibit = 1'b1;
    for (int i = 0; i < 17; i++) begin
      b = 8'($urandom_range(0, 255));
      @(negedge clk);
      if (i == 16) chk("fifo_full_after_16", 32'(bus.full), 1);
      else         chk("fifo_not_full", 32'(bus.full), 0);
      bus.wr_stb  = 1'b1;
      bus.wr_data = b;
      if (i < 16) exp_q.push_back(b);
    end
    @(negedge clk);
    bus.wr_stb = 1'b0;
    chk("fifo_overflow", 32'(bus.overflow), 1);
    bus.inhibit = 1'b0;
`else
    b = 8'($urandom_range(0, 255));
    @(negedge clk);
    bus.wr_stb  = 1'b1;
    bus.wr_data = b;
    exp_q.push_back(b);
    @(negedge clk);
    chk("hold_full", 32'(bus.full), 1);
    chk("hold_no_ovf_yet", 32'(bus.overflow), 0);
    bus.wr_data = ~b;
    @(negedge clk);
    bus.wr_stb = 1'b0;
    chk("hold_overflow", 32'(bus.overflow), 1);
`endif
    drain("drain_overflow");
    chk("overflow_sticky", 32'(bus.overflow), 1);

    // Inhibit: nothing moves while held; release starts the frame one cycle later.
    bus.inhibit = 1'b1;
    wr(8'h5A); exp_q.push_back(8'h5A);
    quiet = 0;
    repeat (40) begin
      @(negedge clk);
      if (!ps2_clk || !ps2_data) quiet++;
    end
    chk("inhibit_quiet", 32'(quiet), 0);
    chk("inhibit_not_busy", 32'(bus.busy), 0);
    bus.inhibit = 1'b0;
    @(negedge clk);
    chk("inhibit_release_start", 32'(ps2_data), 0);
    base_f = falls;
    wait_falls(base_f + 4);
    bus.inhibit = 1'b1;
    drain("drain_inhibit");
    chk("inhibit_midframe_frame", 32'(frame_bits), 32'(frame_of(8'h5A)));
    chk("inhibit_midframe_falls", 32'(falls - base_f), 11);
    bus.inhibit = 1'b0;

    // Asynchronous reset during bit 5 of 0x1C.
    base_f = falls;
    wr(8'h1C); exp_q.push_back(8'h1C);
    wait_falls(base_f + 7);
    @(negedge clk);
    chk("rst_pre_clk_low", 32'(ps2_clk), 0);
    #1 reset = 1'b1;
    #1;
    chk("async_rst_clk", 32'(ps2_clk), 1);
    chk("async_rst_data", 32'(ps2_data), 1);
    chk("async_rst_busy", 32'(bus.busy), 0);
    chk("async_rst_full", 32'(bus.full), 0);
    chk("async_rst_overflow", 32'(bus.overflow), 0);
    exp_q.delete();
    @(negedge clk);
    reset = 1'b0;
    base_r = frames_rx;
    wr(8'h29); exp_q.push_back(8'h29);
    wait_frames(base_r + 1);
    chk("frame_29", 32'(frame_bits), 32'h452);
    drain("drain_after_reset");

    // All byte values in shuffled order with random spacing.
    for (int i = 0; i < 256; i++) order[i] = 8'(i);
    for (int i = 255; i > 0; i--) begin
      int j;
      j = $urandom_range(0, i);
      b = order[i];
      order[i] = order[j];
      order[j] = b;
    end
    base_r = frames_rx;
    for (int i = 0; i < 256; i++) begin
      wait_not_full();
      repeat ($urandom_range(0, 2)) @(negedge clk);
      exp_q.push_back(order[i]);
      wr(order[i]);
    end
    drain("drain_sweep");
    chk("sweep_frames", 32'(frames_rx - base_r), 256);
    chk("sweep_no_overflow", 32'(bus.overflow), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
